// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO DAC modulator.
//   - mode_e          : operating modes (OFF / PWM / SDM)
//   - CODE_*          : raw cfgIn[1:0] mode codes
//   - PWM_LAST        : last counter value of a PWM period (period = 255)
//   - convert_sample  : offset-binary conversion of a signed sample
//   - decode_mode     : maps a raw mode code onto mode_e
package nco_pkg;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_PWM = 2'd1,
        MODE_SDM = 2'd2
    } mode_e;

    localparam logic [1:0] CODE_OFF     = 2'd0;
    localparam logic [1:0] CODE_PWM     = 2'd1;
    localparam logic [1:0] CODE_SDM     = 2'd2;
    localparam logic [1:0] CODE_OFF_ALT = 2'd3;

    localparam logic [7:0] PWM_LAST = 8'd254;

    // Flipping the MSB maps two's complement -128..127 onto 0..255.
    function automatic logic [7:0] convert_sample(input logic [7:0] sample,
                                                  input logic       is_signed);
        logic [7:0] result;
        if (is_signed) begin
            result = {~sample[7], sample[6:0]};
        end else begin
            result = sample;
        end
        return result;
    endfunction

    // Code 3 is an alias for off.
    function automatic mode_e decode_mode(input logic [1:0] code);
        mode_e result;
        case (code)
            CODE_OFF:     result = MODE_OFF;
            CODE_PWM:     result = MODE_PWM;
            CODE_SDM:     result = MODE_SDM;
            CODE_OFF_ALT: result = MODE_OFF;
            default:      result = MODE_OFF;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/nco_sdm1.sv
// nco_sdm1: first-order sigma-delta accumulator.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset (clears the accumulator)
//   enable  in   clock enable; accumulator holds when low
//   clear   in   forces the accumulator to zero on an enabled cycle
//   duty    in   8-bit unsigned duty value added every enabled cycle
//   bit_out out  carry of acc + duty; the parent registers it as the DAC bit
module nco_sdm1
    import nco_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic [7:0] duty,
    output logic       bit_out
);

    logic [7:0] acc_r;
    logic [8:0] sum_s;

    assign sum_s   = {1'b0, acc_r} + {1'b0, duty};
    // The carry out of the 8-bit accumulator is the 1-bit density output.
    assign bit_out = sum_s[8];

    // Accumulator register: cleared on reset or request, otherwise keeps the residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 8'd0;
        end else if (enable) begin
            if (clear) begin
                acc_r <= 8'd0;
            end else begin
                acc_r <= sum_s[7:0];
            end
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/nco_dac_modulator.sv
// nco_dac_modulator: converts NCO samples into a 1-bit DAC bitstream using
// either 255-cycle PWM or first-order sigma-delta modulation.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   enable       in   clock enable shared with the upstream NCO
//   sampleIn     in   8-bit sample from the NCO
//   cfgIn        in   [1:0] mode (0 off, 1 PWM, 2 SDM, 3 off), [2] signed sample
//   dacOut       out  registered DAC bit
//   sampleTaken  out  registered pulse: the duty register was loaded on the previous edge
module nco_dac_modulator
    import nco_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] sampleIn,
    input  logic [2:0] cfgIn,
    output logic       dacOut,
    output logic       sampleTaken
);

    localparam logic [1:0] ST_OFF = MODE_OFF;
    localparam logic [1:0] ST_PWM = MODE_PWM;
    localparam logic [1:0] ST_SDM = MODE_SDM;

    logic [1:0] state_r;
    logic [7:0] cnt_r;
    logic [7:0] duty_r;
    logic       dac_r;
    logic       taken_r;

    logic [1:0] decoded_s;
    logic [7:0] converted_s;
    logic       mode_change_s;
    logic       sdm_clear_s;
    logic       sdm_bit_s;

    assign decoded_s     = decode_mode(cfgIn[1:0]);
    assign converted_s   = convert_sample(sampleIn, cfgIn[2]);
    assign mode_change_s = (decoded_s != state_r);
    // The accumulator only runs while settled in SDM; any entry starts it from zero.
    assign sdm_clear_s   = mode_change_s || (state_r != ST_SDM);

    nco_sdm1 u_sdm (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (sdm_clear_s),
        .duty    (duty_r),
        .bit_out (sdm_bit_s)
    );

    // Mode FSM, PWM counter, duty register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_OFF;
            cnt_r   <= 8'd0;
            duty_r  <= 8'd0;
            dac_r   <= 1'b0;
            taken_r <= 1'b0;
        end else if (!enable) begin
            taken_r <= 1'b0;
        end else if (mode_change_s) begin
            state_r <= decoded_s;
            cnt_r   <= 8'd0;
            duty_r  <= converted_s;
            dac_r   <= 1'b0;
            taken_r <= (decoded_s != ST_OFF);
        end else begin
            case (state_r)
                ST_PWM: begin
                    // High for cnt = 0 .. duty-1; the wrap at PWM_LAST gives 255 cycles.
                    dac_r <= (cnt_r < duty_r);
                    if (cnt_r == PWM_LAST) begin
                        cnt_r   <= 8'd0;
                        duty_r  <= converted_s;
                        taken_r <= 1'b1;
                    end else begin
                        cnt_r   <= cnt_r + 8'd1;
                        taken_r <= 1'b0;
                    end
                end
                ST_SDM: begin
                    dac_r   <= sdm_bit_s;
                    duty_r  <= converted_s;
                    taken_r <= 1'b1;
                end
                ST_OFF: begin
                    dac_r   <= 1'b0;
                    cnt_r   <= 8'd0;
                    taken_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_OFF;
                    cnt_r   <= 8'd0;
                    dac_r   <= 1'b0;
                    taken_r <= 1'b0;
                end
            endcase
        end
    end

    assign dacOut      = dac_r;
    assign sampleTaken = taken_r;

endmodule

// File: tb/tb_nco_dac_modulator.sv
// Self-checking bench for nco_dac_modulator: a per-cycle reference model
// checked continuously, plus directed scenarios with hand-computed counts.
module tb_nco_dac_modulator;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] sampleIn;
    logic [2:0] cfgIn;
    logic       dacOut;
    logic       sampleTaken;

    int n_cmp;
    int n_err;

    nco_dac_modulator dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sampleIn    (sampleIn),
        .cfgIn       (cfgIn),
        .dacOut      (dacOut),
        .sampleTaken (sampleTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 off, 1 pwm, 2 sdm; position = place within the 255-cycle PWM period
    int m_mode;
    int m_pos;
    int m_duty;
    int m_acc;
    int m_dac;
    int m_taken;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        m_mode = 0; m_pos = 0; m_duty = 0; m_acc = 0; m_dac = 0; m_taken = 0;
    end

    // Advance the model at every edge from the inputs, then compare just after.
    always @(posedge clk) begin
        int want;
        int value;
        int total;
        value = cfgIn[2] ? ((int'(sampleIn) + 128) % 256) : int'(sampleIn);
        want  = (cfgIn[1:0] == 2'd1) ? 1 : ((cfgIn[1:0] == 2'd2) ? 2 : 0);
        if (rst) begin
            m_mode = 0; m_pos = 0; m_duty = 0; m_acc = 0; m_dac = 0; m_taken = 0;
        end else if (!enable) begin
            m_taken = 0;
        end else if (want != m_mode) begin
            m_mode = want; m_pos = 0; m_acc = 0; m_duty = value; m_dac = 0;
            m_taken = (want != 0) ? 1 : 0;
        end else if (m_mode == 1) begin
            m_dac = (m_pos < m_duty) ? 1 : 0;
            m_pos = (m_pos + 1) % 255;
            if (m_pos == 0) begin
                m_duty = value; m_taken = 1;
            end else begin
                m_taken = 0;
            end
        end else if (m_mode == 2) begin
            total   = m_acc + m_duty;
            m_dac   = (total >= 256) ? 1 : 0;
            m_acc   = total % 256;
            m_duty  = value;
            m_taken = 1;
        end else begin
            m_dac = 0; m_taken = 0;
        end
        #1;
        check("model_dacOut", int'(dacOut), m_dac);
        check("model_sampleTaken", int'(sampleTaken), m_taken);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic e, input logic [2:0] c, input logic [7:0] s);
        @(negedge clk);
        rst = r; enable = e; cfgIn = c; sampleIn = s;
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic count_cycles(input int n, output int highs, output int takes);
        highs = 0;
        takes = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            highs += int'(dacOut);
            takes += int'(sampleTaken);
        end
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b0, 3'd0, 8'd0);
        tick();
        tick();
    endtask

    task automatic pwm_period(input string name, input logic [2:0] cfg, input logic [7:0] s,
                              input int exp_high);
        int h;
        int t;
        do_reset();
        drive(1'b0, 1'b1, cfg, s);
        tick();
        check({name, "_entry_taken"}, int'(sampleTaken), 1);
        count_cycles(255, h, t);
        check({name, "_high"}, h, exp_high);
        check({name, "_taken"}, t, 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int h;
        int t;
        int pat[4];
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; enable = 1'b0; cfgIn = 3'd0; sampleIn = 8'd0;
        pat[0] = 0; pat[1] = 0; pat[2] = 0; pat[3] = 1;

        do_reset();
        check("reset_dacOut", int'(dacOut), 0);
        check("reset_taken", int'(sampleTaken), 0);

        // PWM 0x40: 64 high then 191 low, contiguous from the period start
        do_reset();
        drive(1'b0, 1'b1, 3'b001, 8'h40);
        tick();
        check("pwm40_entry_dac", int'(dacOut), 0);
        check("pwm40_entry_taken", int'(sampleTaken), 1);
        h = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (int'(dacOut) != ((i < 64) ? 1 : 0)) h++;
        end
        check("pwm40_shape_errors", h, 0);
        count_cycles(255, h, t);
        check("pwm40_high_2nd", h, 64);
        check("pwm40_taken_2nd", t, 1);

        pwm_period("pwm00", 3'b001, 8'h00, 0);
        pwm_period("pwmFF", 3'b001, 8'hFF, 255);
        pwm_period("spwm80", 3'b101, 8'h80, 0);
        pwm_period("spwm00", 3'b101, 8'h00, 128);
        pwm_period("spwm7F", 3'b101, 8'h7F, 255);

        // sample change mid-period takes effect at the wrap
        do_reset();
        drive(1'b0, 1'b1, 3'b001, 8'h40);
        tick();
        count_cycles(100, h, t);
        check("midchg_first100", h, 64);
        drive(1'b0, 1'b1, 3'b001, 8'h80);
        count_cycles(155, h, t);
        check("midchg_rest_high", h, 0);
        check("midchg_rest_taken", t, 1);
        count_cycles(255, h, t);
        check("midchg_next_high", h, 128);

        // enable freeze at cnt = 50
        do_reset();
        drive(1'b0, 1'b1, 3'b001, 8'h40);
        tick();
        count_cycles(50, h, t);
        check("freeze_pre_high", h, 50);
        drive(1'b0, 1'b0, 3'b001, 8'h10);
        h = 0;
        t = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            h += int'(dacOut);
            t += int'(sampleTaken);
        end
        check("freeze_dac_held", h, 10);
        check("freeze_taken", t, 0);
        drive(1'b0, 1'b1, 3'b001, 8'h40);
        count_cycles(205, h, t);
        check("freeze_post_high", h, 14);
        check("freeze_post_taken", t, 1);

        // SDM 0x40: 0,0,0,1 repeating, 64 ones per 256
        do_reset();
        drive(1'b0, 1'b1, 3'b010, 8'h40);
        tick();
        check("sdm_entry_dac", int'(dacOut), 0);
        check("sdm_entry_taken", int'(sampleTaken), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("sdm_pattern", int'(dacOut), pat[i % 4]);
        end
        count_cycles(256, h, t);
        check("sdm_ones", h, 64);
        check("sdm_taken", t, 256);

        // PWM -> SDM at cnt = 100, then reset pulse while SDM outputs a one
        do_reset();
        drive(1'b0, 1'b1, 3'b001, 8'hFF);
        tick();
        count_cycles(100, h, t);
        check("p2s_pwm_high", h, 100);
        drive(1'b0, 1'b1, 3'b010, 8'h40);
        tick();
        check("p2s_dac", int'(dacOut), 0);
        check("p2s_taken", int'(sampleTaken), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("p2s_pattern", int'(dacOut), pat[i]);
        end
        drive(1'b1, 1'b1, 3'b010, 8'h40);
        tick();
        check("sdm_rst_dac", int'(dacOut), 0);
        check("sdm_rst_taken", int'(sampleTaken), 0);
        drive(1'b0, 1'b1, 3'b010, 8'h40);
        tick();
        check("sdm_reentry_taken", int'(sampleTaken), 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nco_dac_modulator.md
NCO_DAC_MODULATOR -- requirements
Module: nco_dac_modulator

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have one clock and a synchronous active-high reset: `clk` is the single clock, and `rst` is the reset.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 enable  input  1  clock-enable shared with the upstream NCO.
REQ-006 sampleIn  input  8  sample from the NCO dataOut.
REQ-007 cfgIn  input  3  configuration bits:
- [1:0] mode: 0 = off, 1 = PWM, 2 = sigma-delta (SDM), 3 = off.
- [2] signed: 1 = sampleIn is two's complement.
REQ-008 dacOut  output  1  registered 1-bit DAC bitstream.
REQ-009 sampleTaken  output  1  registered one-cycle pulse; high when dutyReg loaded on the previous edge.

Function
REQ-010 The converted sample SHALL be {~sampleIn[7], sampleIn[6:0]} when cfgIn[2]=1, and sampleIn unchanged otherwise.
REQ-011 The FSM SHALL have states OFF, PWM, SDM. The decoded mode is sampled on every enabled cycle.
REQ-012 On an enabled cycle where the decoded mode differs from the current state, the block SHALL do all of the following, and no other state update that cycle:
- state <= decoded mode;
- cnt <= 0; acc <= 0;
- dutyReg <= converted sample;
- dacOut <= 0;
- sampleTaken <= 1 if the new state is PWM or SDM, else 0.
REQ-013 OFF behaviour: dacOut <= 0, cnt and acc held at 0, sampleTaken <= 0.
REQ-014 PWM behaviour (enabled cycle, no mode change):
- dacOut <= (cnt < dutyReg), using an 8-bit unsigned compare;
- if cnt == 254: cnt <= 0, dutyReg <= converted sample, sampleTaken <= 1;
- else: cnt <= cnt + 1, sampleTaken <= 0.
REQ-015 The PWM period SHALL be exactly 255 enabled cycles with exactly dutyReg high cycles per period, contiguous from cnt = 0. Duty 0x00 gives constant low; 0xFF gives constant high.
REQ-016 SDM behaviour (enabled cycle, no mode change):
- sum = {1'b0, acc} + {1'b0, dutyReg}, 9 bits;
- acc <= sum[7:0]; dacOut <= sum[8];
- dutyReg <= converted sample; sampleTaken <= 1.
REQ-017 In SDM with constant duty D and acc starting at 0, dacOut SHALL contain exactly D ones in every 256 consecutive cycles.
REQ-018 When enable=0, all state (FSM, cnt, acc, dutyReg, dacOut) SHALL hold, and sampleTaken SHALL be 0.
REQ-019 Latency from a sample change to its first effect on dacOut SHALL be:
- 2 enabled cycles in SDM;
- at most 256 enabled cycles in PWM (change takes effect at the next period boundary).

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL set state = OFF, cnt = 0, acc = 0, dutyReg = 0, dacOut = 0, sampleTaken = 0. Reset dominates enable and any mode change.
REQ-021 Reset asserted mid-period or mid-accumulation SHALL discard all progress. After reset releases, a non-off mode follows the entry rule in REQ-012.

Structure
REQ-022 The following SHALL live in a shared package nco_pkg: the mode enum (OFF/PWM/SDM), the mode code constants, and PWM_LAST = 254.
REQ-023 The SDM accumulator SHALL be a sub-module nco_sdm1: inputs clk, rst, enable, clear, duty[7:0]; output bit. The PWM counter and FSM stay in the top module.

Verification
REQ-024 Reset, then PWM with unsigned 0x40 held constant -> sampleTaken pulses once per 255 cycles; after the entry cycle, dacOut repeats 64 high then 191 low.
REQ-025 PWM boundaries:
- 0x00 -> dacOut never high;
- 0xFF -> dacOut constantly high from the second cycle after entry;
- new sample 0x80 presented at cnt = 100 -> duty unchanged until cnt wraps, then 128 high per period.
REQ-026 Signed PWM:
- 0x80 -> dacOut always low;
- 0x00 -> 128 high per period;
- 0x7F -> 255 high (constant).
REQ-027 SDM with unsigned 0x40 -> dacOut = 0,0,0,1 repeating; exactly 64 ones per 256 cycles; sampleTaken high every enabled cycle.
REQ-028 enable low for 10 cycles at cnt = 50 -> cnt, dacOut, and dutyReg frozen, sampleTaken 0; the period then completes with correct high count.
REQ-029 Mode and reset interruptions:
- PWM -> SDM at cnt = 100 -> next edge gives dacOut = 0, cnt = 0, acc = 0, sampleTaken = 1;
- rst pulse in SDM -> all outputs 0 on the next edge.
